// File: rtl/fsmc_mem_bridge.sv
// FSMC-to-block-RAM bridge: four host registers (DATA, INDEX, CTRL, STATUS)
// behind an asynchronous STM32 FSMC bank. The strobes, address and data are
// resynchronised into the PLL clock domain. Reads of DATA come from a
// prefetch register, so the first read after an INDEX write returns
// mem[index].
module fsmc_mem_bridge #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 512,
  parameter int IDX_W       = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              noe,
  input  logic              nwe,
  input  logic              ncs,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [IDX_W-1:0]  index_out
);

  localparam logic [1:0]        A_DATA   = 2'd0;
  localparam logic [1:0]        A_INDEX  = 2'd1;
  localparam logic [1:0]        A_CTRL   = 2'd2;
  localparam logic [1:0]        A_STATUS = 2'd3;
  localparam logic [IDX_W-1:0]  LAST     = IDX_W'(DEPTH - 1);
  localparam logic [DATA_W:0]   DEPTH_D  = (DATA_W + 1)'(DEPTH);

  // synchroniser chains; strobes idle high, addr/data delayed identically
  logic [SYNC_STAGES-1:0]             noe_sy, nwe_sy, ncs_sy;
  logic [SYNC_STAGES-1:0][1:0]        addr_sy;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] din_sy;
  logic                               noe_q, nwe_q;

  logic              noe_s, nwe_s, ncs_s, sel;
  logic [1:0]        a_s;
  logic [DATA_W-1:0] d_s;
  logic              rd_strobe, wr_strobe;

  // architectural state
  logic [IDX_W-1:0]  index;
  logic              autoinc, wrap_en;
  logic [2:0]        sticky;   // {ERR_COLLIDE, ERR_RANGE, WRAPPED}
  logic [DATA_W-1:0] pf;
  logic [DATA_W-1:0] mem [DEPTH];

  // next-state terms
  logic              do_rd, do_wr, collide, bump;
  logic              set_wrap, set_range;
  logic [IDX_W-1:0]  idx_d;
  logic [2:0]        clr, sticky_d;
  logic [DATA_W-1:0] rd_val;

  // Shift the async bus signals through the synchroniser and keep one extra
  // flop of noe/nwe for edge detection.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      noe_sy  <= '1;
      nwe_sy  <= '1;
      ncs_sy  <= '1;
      addr_sy <= '0;
      din_sy  <= '0;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
    end else begin
      noe_sy  <= {noe_sy[SYNC_STAGES-2:0], noe};
      nwe_sy  <= {nwe_sy[SYNC_STAGES-2:0], nwe};
      ncs_sy  <= {ncs_sy[SYNC_STAGES-2:0], ncs};
      addr_sy <= {addr_sy[SYNC_STAGES-2:0], addr};
      din_sy  <= {din_sy[SYNC_STAGES-2:0], data_in};
      noe_q   <= noe_sy[SYNC_STAGES-1];
      nwe_q   <= nwe_sy[SYNC_STAGES-1];
    end
  end

  assign noe_s     = noe_sy[SYNC_STAGES-1];
  assign nwe_s     = nwe_sy[SYNC_STAGES-1];
  assign ncs_s     = ncs_sy[SYNC_STAGES-1];
  assign a_s       = addr_sy[SYNC_STAGES-1];
  assign d_s       = din_sy[SYNC_STAGES-1];
  assign sel       = ~ncs_s;
  // a read fires on the falling edge of noe, a write on the rising edge of nwe
  assign rd_strobe = noe_q & ~noe_s & sel;
  assign wr_strobe = ~nwe_q & nwe_s & sel;
  // driven only from flops, so the pad enable cannot glitch
  assign data_oe   = ~noe_s & sel;
  assign index_out = index;

  // Decode the strobe. A write wins a collision, then work out the index
  // update and the sticky-flag update.
  always_comb begin
    do_wr     = wr_strobe;
    do_rd     = rd_strobe & ~wr_strobe;
    collide   = rd_strobe & wr_strobe;
    bump      = (do_wr | do_rd) && (a_s == A_DATA) && autoinc;
    idx_d     = index;
    set_wrap  = 1'b0;
    set_range = 1'b0;
    if (bump) begin
      if (index == LAST) begin
        if (wrap_en) begin
          idx_d    = '0;
          set_wrap = 1'b1;
        end else begin
          set_range = 1'b1;
        end
      end else begin
        idx_d = index + 1'b1;
      end
    end
    // out-of-range INDEX writes are checked against the full bus value
    if (do_wr && a_s == A_INDEX) begin
      if ({1'b0, d_s} >= DEPTH_D) set_range = 1'b1;
      else                        idx_d     = d_s[IDX_W-1:0];
    end
    clr      = (do_wr && a_s == A_STATUS) ? d_s[2:0] : 3'b000;
    // a flag raised this cycle survives a simultaneous write-1-to-clear
    sticky_d = (sticky & ~clr) | {collide, set_range, set_wrap};
  end

  // Select the value a read returns for the addressed register.
  always_comb begin
    rd_val = '0;
    case (a_s)
      A_DATA:   rd_val             = pf;
      A_INDEX:  rd_val[IDX_W-1:0]  = index;
      A_CTRL:   rd_val[1:0]        = {wrap_en, autoinc};
      default:  rd_val[2:0]        = sticky;
    endcase
  end

  // Update the host-visible registers and the read latch.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      index    <= '0;
      autoinc  <= 1'b1;
      wrap_en  <= 1'b0;
      sticky   <= '0;
      data_out <= '0;
    end else begin
      index  <= idx_d;
      sticky <= sticky_d;
      if (do_wr && a_s == A_CTRL) begin
        autoinc <= d_s[0];
        wrap_en <= d_s[1];
      end
      if (do_rd) data_out <= rd_val;
    end
  end

  // Block-RAM write port; the contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr && a_s == A_DATA) mem[index] <= d_s;
  end

  // Prefetch mem[index] every cycle so a DATA read never waits on the RAM.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) pf <= '0;
    else          pf <= mem[index];
  end

endmodule

// File: tb/tb_fsmc_mem_bridge.sv
// Bench for fsmc_mem_bridge. A table of bus operations carries the expected
// read data and index. Read expectations go onto a queue when the read is
// issued and are checked when the latched data appears. Collision and reset
// get their own hand-written sequences.
module tb_fsmc_mem_bridge;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam int IDX_W  = 9;

  logic              clk = 1'b0;
  logic              reset_l = 1'b0;
  logic              noe = 1'b1, nwe = 1'b1, ncs = 1'b1;
  logic [1:0]        addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [IDX_W-1:0]  index_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic              wr;
    logic [1:0]        a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;
    logic              ci;
    logic [IDX_W-1:0]  ei;
  } vec_t;

  vec_t              tbl[$];
  logic [DATA_W-1:0] exp_q[$];

  fsmc_mem_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_l(reset_l), .noe(noe), .nwe(nwe), .ncs(ncs), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .index_out(index_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    ncs = 1'b0; addr = a; data_in = d; nwe = 1'b0;
    cyc(4);
    nwe = 1'b1;
    cyc(4);
    ncs = 1'b1;
    cyc(2);
  endtask

  task automatic bus_read(input logic [1:0] a, input string name);
    logic [DATA_W-1:0] e;
    ncs = 1'b0; addr = a; noe = 1'b0;
    cyc(6);
    check({name, "_oe"}, 32'(data_oe), 32'd1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(data_out), 32'(e));
    end
    noe = 1'b1;
    cyc(2);
    ncs = 1'b1;
    cyc(3);
  endtask

  function automatic vec_t wv(input logic [1:0] a, input logic [DATA_W-1:0] d,
                              input logic ci, input logic [IDX_W-1:0] ei);
    vec_t v;
    v.wr = 1'b1; v.a = a; v.d = d; v.exp = '0; v.ci = ci; v.ei = ei;
    return v;
  endfunction

  function automatic vec_t rv(input logic [1:0] a, input logic [DATA_W-1:0] exp,
                              input logic ci, input logic [IDX_W-1:0] ei);
    vec_t v;
    v.wr = 1'b0; v.a = a; v.d = '0; v.exp = exp; v.ci = ci; v.ei = ei;
    return v;
  endfunction

  initial begin
    // sequential fill and readback
    tbl.push_back(wv(2'd1, 16'd0,    1, 9'd0));
    tbl.push_back(wv(2'd0, 16'hA001, 1, 9'd1));
    tbl.push_back(wv(2'd0, 16'hA002, 1, 9'd2));
    tbl.push_back(wv(2'd0, 16'hA003, 1, 9'd3));
    tbl.push_back(wv(2'd1, 16'd0,    1, 9'd0));
    tbl.push_back(rv(2'd0, 16'hA001, 1, 9'd1));
    tbl.push_back(rv(2'd0, 16'hA002, 1, 9'd2));
    tbl.push_back(rv(2'd0, 16'hA003, 1, 9'd3));
    // first read after an INDEX write comes from mem[index]
    tbl.push_back(wv(2'd1, 16'd5,    1, 9'd5));
    tbl.push_back(wv(2'd0, 16'h5A5A, 1, 9'd6));
    tbl.push_back(wv(2'd1, 16'd5,    1, 9'd5));
    tbl.push_back(rv(2'd0, 16'h5A5A, 1, 9'd6));
    tbl.push_back(rv(2'd1, 16'd6,    0, 9'd0));
    // wrap enabled
    tbl.push_back(wv(2'd2, 16'h3,    0, 9'd0));
    tbl.push_back(rv(2'd2, 16'h3,    0, 9'd0));
    tbl.push_back(wv(2'd1, 16'd511,  1, 9'd511));
    tbl.push_back(wv(2'd0, 16'h1234, 1, 9'd0));
    tbl.push_back(rv(2'd3, 16'h1,    0, 9'd0));
    tbl.push_back(wv(2'd3, 16'h1,    0, 9'd0));
    tbl.push_back(rv(2'd3, 16'h0,    1, 9'd0));
    tbl.push_back(wv(2'd1, 16'd511,  1, 9'd511));
    tbl.push_back(rv(2'd0, 16'h1234, 1, 9'd0));
    tbl.push_back(rv(2'd3, 16'h1,    0, 9'd0));
    tbl.push_back(wv(2'd3, 16'h7,    0, 9'd0));
    // saturate at the top and out-of-range INDEX
    tbl.push_back(wv(2'd2, 16'h1,    0, 9'd0));
    tbl.push_back(wv(2'd1, 16'd511,  1, 9'd511));
    tbl.push_back(rv(2'd0, 16'h1234, 1, 9'd511));
    tbl.push_back(rv(2'd3, 16'h2,    0, 9'd0));
    tbl.push_back(wv(2'd3, 16'h7,    0, 9'd0));
    tbl.push_back(rv(2'd3, 16'h0,    0, 9'd0));
    tbl.push_back(wv(2'd1, 16'd512,  1, 9'd511));
    tbl.push_back(rv(2'd1, 16'd511,  0, 9'd0));
    tbl.push_back(rv(2'd3, 16'h2,    0, 9'd0));
    tbl.push_back(wv(2'd3, 16'h2,    0, 9'd0));
    // auto-increment off
    tbl.push_back(wv(2'd2, 16'h0,    0, 9'd0));
    tbl.push_back(wv(2'd1, 16'd7,    1, 9'd7));
    tbl.push_back(wv(2'd0, 16'h0777, 1, 9'd7));
    tbl.push_back(rv(2'd0, 16'h0777, 1, 9'd7));
    tbl.push_back(rv(2'd0, 16'h0777, 1, 9'd7));
    tbl.push_back(rv(2'd1, 16'd7,    1, 9'd7));

    // reset state
    cyc(2);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_index", 32'(index_out), 32'd0);
    reset_l = 1'b1;
    cyc(3);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].a, tbl[i].d);
      end else begin
        exp_q.push_back(tbl[i].exp);
        bus_read(tbl[i].a, $sformatf("vec%0d", i));
      end
      if (tbl[i].ci) check($sformatf("vec%0d_idx", i), 32'(index_out), 32'(tbl[i].ei));
    end

    // collision: the nwe rising edge and the noe falling edge land together
    ncs = 1'b0; addr = 2'd0; data_in = 16'hC011; nwe = 1'b0;
    cyc(4);
    noe = 1'b0; nwe = 1'b1;
    cyc(6);
    check("coll_latch_held", 32'(data_out), 32'd7);
    check("coll_idx", 32'(index_out), 32'd7);
    noe = 1'b1;
    cyc(2);
    ncs = 1'b1;
    cyc(3);
    exp_q.push_back(16'h4);
    bus_read(2'd3, "coll_status");
    exp_q.push_back(16'hC011);
    bus_read(2'd0, "coll_mem");
    bus_write(2'd3, 16'h4);
    exp_q.push_back(16'h0);
    bus_read(2'd3, "coll_clr");

    // reset asserted in the middle of a read
    ncs = 1'b0; addr = 2'd1; noe = 1'b0;
    cyc(6);
    check("mid_oe_before", 32'(data_oe), 32'd1);
    #2 reset_l = 1'b0;
    #1;
    check("mid_oe_dropped", 32'(data_oe), 32'd0);
    check("mid_data_out", 32'(data_out), 32'd0);
    check("mid_index", 32'(index_out), 32'd0);
    noe = 1'b1; ncs = 1'b1;
    cyc(3);
    reset_l = 1'b1;
    cyc(3);
    exp_q.push_back(16'h0);
    bus_read(2'd1, "post_rst_index");
    exp_q.push_back(16'h1);
    bus_read(2'd2, "post_rst_ctrl");

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
